alu_top: RTL and testbench
==========================

ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 Op_Width, default 16, operand/result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 A  input  Op_Width  operand A, unsigned.
REQ-005 B  input  Op_Width  operand B, unsigned.
REQ-006 ALU_FUN  input  4  opcode; [3:2] selects unit, [1:0] selects operation.
REQ-007 Arith_OUT  output  Op_Width  registered arithmetic result.
REQ-008 Carry_OUT  output  1  registered carry/borrow/overflow of arithmetic unit.
REQ-009 Logic_OUT  output  Op_Width  registered logic result.
REQ-010 CMP_OUT  output  Op_Width  registered compare code.
REQ-011 Shift_OUT  output  Op_Width  registered shift result.
REQ-012 Arith_FLAG / Logic_FLAG / CMP_FLAG / Shift_FLAG  output  1 each  registered "this unit executed" flags.

Function
REQ-013 Unit select: ALU_FUN[3:2] 00 arith, 01 logic, 10 compare, 11 shift; exactly one unit enabled per cycle.
REQ-014 Latency 1 cycle: inputs sampled at rising edge N appear on outputs after edge N, held until next edge.
REQ-015 Enabled unit SHALL load its result and set its FLAG to 1; every non-enabled unit SHALL load 0 into its OUT and 0 into its FLAG on the same edge.
REQ-016 Arith 00: A+B modulo 2^Op_Width, Carry_OUT = carry out of MSB.
REQ-017 Arith 01: A-B modulo 2^Op_Width, Carry_OUT = 1 when A<B (borrow).
REQ-018 Arith 10: A*B low Op_Width bits, Carry_OUT = 1 when upper Op_Width product bits nonzero.
REQ-019 Arith 11: A/B integer quotient, Carry_OUT = 0; B=0 SHALL give Arith_OUT = 0.
REQ-020 Carry_OUT SHALL be 0 whenever the arithmetic unit is not enabled.
REQ-021 Logic 00 A&B, 01 A|B, 10 ~(A&B), 11 ~(A|B), bitwise.
REQ-022 Compare (unsigned) 00 NOP -> 0; 01 -> 1 if A==B else 0; 10 -> 2 if A>B else 0; 11 -> 3 if A<B else 0.
REQ-023 Shift (logical, 1 bit, zero fill) 00 A>>1, 01 A<<1, 10 B>>1, 11 B<<1; shifted-out bit discarded.
REQ-024 Opcode change mid-stream: each edge evaluates the current opcode only; no pipelined state beyond the output registers.

Reset
REQ-025 RST low at rising edge SHALL clear all OUT buses, Carry_OUT and all FLAGs to 0, overriding any operation.
REQ-026 First operation after RST released SHALL be computed on the first rising edge with RST high.

Structure
REQ-027 Shared package alu_pkg SHALL hold unit-select constants (ARITH, LOGIC, CMP, SHIFT) and the 16 opcode constants.
REQ-028 One sub-module alu_decoder SHALL map ALU_FUN[3:2] to four one-hot enables; the four units and output registers live in alu_top.

Verification
REQ-029 A=4, B=2, ALU_FUN 0000/0001/0010/0011 -> Arith_OUT 6/2/8/2, Arith_FLAG 1, other FLAGs 0.
REQ-030 A=FFFF, B=0001, ALU_FUN 0000 -> Arith_OUT 0000, Carry_OUT 1; A=5, B=0, 0011 -> Arith_OUT 0.
REQ-031 A=AAAA, B=CCCC, ALU_FUN 0100/0101/0110/0111 -> Logic_OUT 8888/EEEE/7777/1111, Arith_OUT 0, Carry_OUT 0.
REQ-032 A=7AF3, B=9785, ALU_FUN 1000/1001/1010/1011 -> CMP_OUT 0/0/0/3; A=B=1234, 1001 -> CMP_OUT 1.
REQ-033 A=7AF3, B=9785, ALU_FUN 1100/1101/1110/1111 -> Shift_OUT 3D79/F5E6/4BC2/2F0A, Shift_FLAG 1.
REQ-034 Any operation active, RST low for one edge -> all outputs and FLAGs 0 after that edge; results resume one edge after RST high.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared unit-select and opcode constants for the ALU
package alu_pkg;

    // Unit select codes carried on ALU_FUN[3:2]
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    // Arithmetic unit opcodes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;

    // Logic unit opcodes
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;

    // Compare unit opcodes
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_EQ   = 4'b1001;
    localparam logic [3:0] OP_GT   = 4'b1010;
    localparam logic [3:0] OP_LT   = 4'b1011;

    // Shift unit opcodes
    localparam logic [3:0] OP_SRA  = 4'b1100;
    localparam logic [3:0] OP_SLA  = 4'b1101;
    localparam logic [3:0] OP_SRB  = 4'b1110;
    localparam logic [3:0] OP_SLB  = 4'b1111;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode and result bundle between the ALU and its user
interface alu_if #(
    parameter int Op_Width = 16
);
    logic [Op_Width-1:0] A;
    logic [Op_Width-1:0] B;
    logic [3:0]          ALU_FUN;
    logic [Op_Width-1:0] Arith_OUT;
    logic                Carry_OUT;
    logic [Op_Width-1:0] Logic_OUT;
    logic [Op_Width-1:0] CMP_OUT;
    logic [Op_Width-1:0] Shift_OUT;
    logic                Arith_FLAG;
    logic                Logic_FLAG;
    logic                CMP_FLAG;
    logic                Shift_FLAG;

    modport master (
        output A, B, ALU_FUN,
        input  Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        input  Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG
    );

    modport slave (
        input  A, B, ALU_FUN,
        output Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
        output Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG
    );
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the unit-select field to one-hot unit enables
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] unit_sel,
    output logic       arith_en,
    output logic       logic_en,
    output logic       cmp_en,
    output logic       shift_en
);

    // Exactly one enable is high for every select value
    always_comb begin
        arith_en = 1'b0;
        logic_en = 1'b0;
        cmp_en   = 1'b0;
        shift_en = 1'b0;
        case (unit_sel)
            ARITH:   arith_en = 1'b1;
            LOGIC:   logic_en = 1'b1;
            CMP:     cmp_en   = 1'b1;
            default: shift_en = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_top.sv
// rtl/alu_top.sv - four-unit ALU with registered per-unit results and flags
module alu_top
    import alu_pkg::*;
#(
    parameter int Op_Width = 16
) (
    input  logic  CLK,
    input  logic  RST,
    alu_if.slave  bus
);

    logic                  arith_en;
    logic                  logic_en;
    logic                  cmp_en;
    logic                  shift_en;

    logic [Op_Width:0]     add_full;
    logic [2*Op_Width-1:0] mul_full;

    logic [Op_Width-1:0]   arith_res;
    logic                  arith_carry;
    logic [Op_Width-1:0]   logic_res;
    logic [Op_Width-1:0]   cmp_res;
    logic [Op_Width-1:0]   shift_res;

    alu_decoder u_decoder (
        .unit_sel (bus.ALU_FUN[3:2]),
        .arith_en (arith_en),
        .logic_en (logic_en),
        .cmp_en   (cmp_en),
        .shift_en (shift_en)
    );

    // Widened sum and full product so carry/overflow come straight from the top bits
    assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
    assign mul_full = {{Op_Width{1'b0}}, bus.A} * {{Op_Width{1'b0}}, bus.B};

    // Arithmetic unit: divide by zero yields zero rather than an all-ones quotient
    always_comb begin
        arith_res   = '0;
        arith_carry = 1'b0;
        case (bus.ALU_FUN)
            OP_ADD: begin
                arith_res   = add_full[Op_Width-1:0];
                arith_carry = add_full[Op_Width];
            end
            OP_SUB: begin
                arith_res   = bus.A - bus.B;
                arith_carry = (bus.A < bus.B);
            end
            OP_MUL: begin
                arith_res   = mul_full[Op_Width-1:0];
                arith_carry = |mul_full[2*Op_Width-1:Op_Width];
            end
            OP_DIV: begin
                arith_res   = (bus.B == '0) ? '0 : bus.A / bus.B;
                arith_carry = 1'b0;
            end
            default: begin
                arith_res   = '0;
                arith_carry = 1'b0;
            end
        endcase
    end

    // Logic unit: bitwise and/or and their complements
    always_comb begin
        logic_res = '0;
        case (bus.ALU_FUN)
            OP_AND:  logic_res = bus.A & bus.B;
            OP_OR:   logic_res = bus.A | bus.B;
            OP_NAND: logic_res = ~(bus.A & bus.B);
            OP_NOR:  logic_res = ~(bus.A | bus.B);
            default: logic_res = '0;
        endcase
    end

    // Compare unit: each true relation reports its own code, false reports zero
    always_comb begin
        cmp_res = '0;
        case (bus.ALU_FUN)
            OP_EQ:   cmp_res = (bus.A == bus.B) ? Op_Width'(1) : '0;
            OP_GT:   cmp_res = (bus.A >  bus.B) ? Op_Width'(2) : '0;
            OP_LT:   cmp_res = (bus.A <  bus.B) ? Op_Width'(3) : '0;
            default: cmp_res = '0;
        endcase
    end

    // Shift unit: single-bit logical shifts with zero fill
    always_comb begin
        shift_res = '0;
        case (bus.ALU_FUN)
            OP_SRA:  shift_res = {1'b0, bus.A[Op_Width-1:1]};
            OP_SLA:  shift_res = {bus.A[Op_Width-2:0], 1'b0};
            OP_SRB:  shift_res = {1'b0, bus.B[Op_Width-1:1]};
            OP_SLB:  shift_res = {bus.B[Op_Width-2:0], 1'b0};
            default: shift_res = '0;
        endcase
    end

    // Output registers: enabled unit loads its result, all others clear to zero
    always_ff @(posedge CLK) begin
        if (!RST) begin
            bus.Arith_OUT  <= '0;
            bus.Carry_OUT  <= 1'b0;
            bus.Logic_OUT  <= '0;
            bus.CMP_OUT    <= '0;
            bus.Shift_OUT  <= '0;
            bus.Arith_FLAG <= 1'b0;
            bus.Logic_FLAG <= 1'b0;
            bus.CMP_FLAG   <= 1'b0;
            bus.Shift_FLAG <= 1'b0;
        end else begin
            bus.Arith_OUT  <= arith_en ? arith_res : '0;
            bus.Carry_OUT  <= arith_en & arith_carry;
            bus.Logic_OUT  <= logic_en ? logic_res : '0;
            bus.CMP_OUT    <= cmp_en   ? cmp_res   : '0;
            bus.Shift_OUT  <= shift_en ? shift_res : '0;
            bus.Arith_FLAG <= arith_en;
            bus.Logic_FLAG <= logic_en;
            bus.CMP_FLAG   <= cmp_en;
            bus.Shift_FLAG <= shift_en;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// tb/tb_alu_top.sv - self-checking bench for alu_top against an arithmetic model
module tb_alu_top;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_if #(.Op_Width(16)) bus ();

    alu_top #(.Op_Width(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs of the most recent model evaluation
    logic [15:0] e_arith, e_logic, e_cmp, e_shift;
    logic        e_carry, e_af, e_lf, e_cf, e_sf;

    function automatic void model(input longint a, input longint b, input int f);
        longint r;
        e_arith = 0; e_logic = 0; e_cmp = 0; e_shift = 0;
        e_carry = 0; e_af = 0; e_lf = 0; e_cf = 0; e_sf = 0;
        case (f / 4)
            0: begin
                e_af = 1;
                case (f % 4)
                    0: begin r = a + b;  e_carry = (r > 65535); end
                    1: begin r = a - b + 65536; e_carry = (a < b); end
                    2: begin r = a * b;  e_carry = (r > 65535); end
                    default: r = (b == 0) ? 0 : a / b;
                endcase
                e_arith = 16'(r % 65536);
            end
            1: begin
                e_lf = 1;
                case (f % 4)
                    0: r = a & b;
                    1: r = a | b;
                    2: r = 65535 - (a & b);
                    default: r = 65535 - (a | b);
                endcase
                e_logic = 16'(r);
            end
            2: begin
                e_cf = 1;
                case (f % 4)
                    0: r = 0;
                    1: r = (a == b) ? 1 : 0;
                    2: r = (a > b) ? 2 : 0;
                    default: r = (a < b) ? 3 : 0;
                endcase
                e_cmp = 16'(r);
            end
            default: begin
                e_sf = 1;
                case (f % 4)
                    0: r = a / 2;
                    1: r = (a * 2) % 65536;
                    2: r = b / 2;
                    default: r = (b * 2) % 65536;
                endcase
                e_shift = 16'(r);
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".arith"},  bus.Arith_OUT,  e_arith);
        chk({tag, ".carry"},  16'(bus.Carry_OUT),  16'(e_carry));
        chk({tag, ".logic"},  bus.Logic_OUT,  e_logic);
        chk({tag, ".cmp"},    bus.CMP_OUT,    e_cmp);
        chk({tag, ".shift"},  bus.Shift_OUT,  e_shift);
        chk({tag, ".aflag"},  16'(bus.Arith_FLAG), 16'(e_af));
        chk({tag, ".lflag"},  16'(bus.Logic_FLAG), 16'(e_lf));
        chk({tag, ".cflag"},  16'(bus.CMP_FLAG),   16'(e_cf));
        chk({tag, ".sflag"},  16'(bus.Shift_FLAG), 16'(e_sf));
    endtask

    task automatic clear_exp();
        e_arith = 0; e_logic = 0; e_cmp = 0; e_shift = 0;
        e_carry = 0; e_af = 0; e_lf = 0; e_cf = 0; e_sf = 0;
    endtask

    // Drive one operation, clock it, then compare every output to the model
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f, input string tag);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.ALU_FUN = f;
        @(posedge clk);
        #1;
        model(longint'(a), longint'(b), int'(f));
        chk_all(tag);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rf;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.A = 16'h1234; bus.B = 16'h0001; bus.ALU_FUN = 4'b0000;

        // Reset holds every output at zero even with an operation presented
        repeat (2) @(posedge clk);
        #1;
        clear_exp();
        chk_all("reset");

        // First operation computes on the first edge with reset high
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model(16'h1234, 16'h0001, 0);
        chk_all("first_op");
        chk("first_op.lit", bus.Arith_OUT, 16'h1235);

        step(16'd4, 16'd2, 4'b0000, "add42");  chk("add42.lit", bus.Arith_OUT, 16'd6);
        step(16'd4, 16'd2, 4'b0001, "sub42");  chk("sub42.lit", bus.Arith_OUT, 16'd2);
        step(16'd4, 16'd2, 4'b0010, "mul42");  chk("mul42.lit", bus.Arith_OUT, 16'd8);
        step(16'd4, 16'd2, 4'b0011, "div42");  chk("div42.lit", bus.Arith_OUT, 16'd2);
        step(16'hFFFF, 16'h0001, 4'b0000, "add_wrap");
        chk("add_wrap.lit", bus.Arith_OUT, 16'h0000);
        chk("add_wrap.carry_lit", 16'(bus.Carry_OUT), 16'd1);
        step(16'd5, 16'd0, 4'b0011, "div0");   chk("div0.lit", bus.Arith_OUT, 16'h0000);
        step(16'd3, 16'd9, 4'b0001, "sub_borrow");
        step(16'h0100, 16'h0100, 4'b0010, "mul_ovf");
        step(16'hAAAA, 16'hCCCC, 4'b0100, "and");  chk("and.lit",  bus.Logic_OUT, 16'h8888);
        step(16'hAAAA, 16'hCCCC, 4'b0101, "or");   chk("or.lit",   bus.Logic_OUT, 16'hEEEE);
        step(16'hAAAA, 16'hCCCC, 4'b0110, "nand"); chk("nand.lit", bus.Logic_OUT, 16'h7777);
        step(16'hAAAA, 16'hCCCC, 4'b0111, "nor");  chk("nor.lit",  bus.Logic_OUT, 16'h1111);
        step(16'h7AF3, 16'h9785, 4'b1000, "nop");  chk("nop.lit", bus.CMP_OUT, 16'd0);
        step(16'h7AF3, 16'h9785, 4'b1001, "eq");   chk("eq.lit",  bus.CMP_OUT, 16'd0);
        step(16'h7AF3, 16'h9785, 4'b1010, "gt");   chk("gt.lit",  bus.CMP_OUT, 16'd0);
        step(16'h7AF3, 16'h9785, 4'b1011, "lt");   chk("lt.lit",  bus.CMP_OUT, 16'd3);
        step(16'h1234, 16'h1234, 4'b1001, "eq_same"); chk("eq_same.lit", bus.CMP_OUT, 16'd1);
        step(16'h9785, 16'h7AF3, 4'b1010, "gt_true");
        step(16'h7AF3, 16'h9785, 4'b1100, "sra");  chk("sra.lit", bus.Shift_OUT, 16'h3D79);
        step(16'h7AF3, 16'h9785, 4'b1101, "sla");  chk("sla.lit", bus.Shift_OUT, 16'hF5E6);
        step(16'h7AF3, 16'h9785, 4'b1110, "srb");  chk("srb.lit", bus.Shift_OUT, 16'h4BC2);
        step(16'h7AF3, 16'h9785, 4'b1111, "slb");  chk("slb.lit", bus.Shift_OUT, 16'h2F0A);

        // One-edge reset in the middle of a stream, then resume
        @(negedge clk);
        bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.ALU_FUN = 4'b0010;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_exp();
        chk_all("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model(16'hFFFF, 16'hFFFF, 2);
        chk_all("resume");

        // Randomized operations with occasional zero divisor and equal operands
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rb = 16'h0000;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            step(ra, rb, rf, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
